// File: rtl/bira_fault_ctrl.sv
// Fault-stream sequencer for the pivot/non-pivot fault CAM in the BIRA path.
// Accepts BIST faults, writes them one at a time into the CAM, tracks CAM
// occupancy, flags overflow as unrepairable and finally hands every valid
// pivot index to the spare-allocation analyzer.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | no run since reset; waits for start
// S_CLEAR    | one cycle, early_term clears the CAM, run bookkeeping zeroed
// S_COLLECT  | bist_ready high, waits for the next fault
// S_WAIT_RSP | fault written to the CAM, waits for the allocation response
// S_ANALYZE  | offers pivot indices 0..pivot_cnt-1 to the analyzer
// S_DONE     | run finished, repairable; waits for start
// S_FAIL     | run finished, unrepairable; waits for start
module bira_fault_ctrl #(
    parameter int PCAM  = 8,
    parameter int NPCAM = 16,
    parameter int ROW_W = 10,
    parameter int COL_W = 10,
    parameter int BNK_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         bist_valid,
    output logic                         bist_ready,
    input  logic [ROW_W-1:0]             bist_row,
    input  logic [COL_W-1:0]             bist_col,
    input  logic [BNK_W-1:0]             bist_bnk,
    input  logic                         bist_last,
    output logic                         cam_wr,
    output logic [ROW_W-1:0]             cam_row,
    output logic [COL_W-1:0]             cam_col,
    output logic [BNK_W-1:0]             cam_bnk,
    input  logic                         cam_rsp_valid,
    input  logic [1:0]                   cam_rsp_type,
    output logic                         early_term,
    output logic                         ana_valid,
    input  logic                         ana_ready,
    output logic [$clog2(PCAM)-1:0]      ana_idx,
    output logic                         busy,
    output logic                         done,
    output logic                         fail,
    output logic [$clog2(PCAM+1)-1:0]    pivot_cnt,
    output logic [$clog2(NPCAM+1)-1:0]   npivot_cnt,
    output logic [CNT_W-1:0]             fault_cnt
);

    localparam int PCW  = $clog2(PCAM + 1);
    localparam int NPCW = $clog2(NPCAM + 1);

    localparam logic [1:0] RSP_MERGED = 2'b00;
    localparam logic [1:0] RSP_PIVOT  = 2'b01;
    localparam logic [1:0] RSP_NPIVOT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COLLECT,
        S_WAIT_RSP,
        S_ANALYZE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t state, state_nxt;
    logic   last_seen;
    logic   fail_pulse;
    logic   rsp_fail;
    logic   idx_is_last;

    // A response overflows when the target CAM is already full; 11 is never legal.
    always_comb begin
        rsp_fail = 1'b0;
        case (cam_rsp_type)
            RSP_PIVOT:  rsp_fail = (pivot_cnt == PCW'(PCAM));
            RSP_NPIVOT: rsp_fail = (npivot_cnt == NPCW'(NPCAM));
            RSP_MERGED: rsp_fail = 1'b0;
            default:    rsp_fail = 1'b1;
        endcase
    end

    assign idx_is_last = (PCW'(ana_idx) == (pivot_cnt - PCW'(1)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and state-derived handshake/status outputs.
    always_comb begin
        state_nxt  = state;
        bist_ready = 1'b0;
        ana_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                busy      = 1'b1;
                state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                busy       = 1'b1;
                bist_ready = 1'b1;
                if (bist_valid) state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                busy = 1'b1;
                if (cam_rsp_valid) begin
                    if (rsp_fail)       state_nxt = S_FAIL;
                    else if (last_seen) state_nxt = S_ANALYZE;
                    else                state_nxt = S_COLLECT;
                end
            end
            S_ANALYZE: begin
                busy = 1'b1;
                if (pivot_cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    ana_valid = 1'b1;
                    if (ana_ready && idx_is_last) state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // CAM clear in CLEAR, plus a one-cycle pulse on the way into FAIL.
    assign early_term = (state == S_CLEAR) || fail_pulse;

    // Run datapath: CAM write port, occupancy/fault counters, analyzer index, result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cam_wr     <= 1'b0;
            cam_row    <= '0;
            cam_col    <= '0;
            cam_bnk    <= '0;
            fault_cnt  <= '0;
            pivot_cnt  <= '0;
            npivot_cnt <= '0;
            ana_idx    <= '0;
            last_seen  <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_pulse <= 1'b0;
        end else begin
            cam_wr     <= 1'b0;
            fail_pulse <= 1'b0;
            case (state)
                S_CLEAR: begin
                    fault_cnt  <= '0;
                    pivot_cnt  <= '0;
                    npivot_cnt <= '0;
                    ana_idx    <= '0;
                    last_seen  <= 1'b0;
                    done       <= 1'b0;
                    fail       <= 1'b0;
                end
                S_COLLECT: begin
                    if (bist_valid) begin
                        cam_wr    <= 1'b1;
                        cam_row   <= bist_row;
                        cam_col   <= bist_col;
                        cam_bnk   <= bist_bnk;
                        last_seen <= bist_last;
                        if (fault_cnt != '1) fault_cnt <= fault_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_RSP: begin
                    if (cam_rsp_valid) begin
                        if (rsp_fail) begin
                            fail       <= 1'b1;
                            fail_pulse <= 1'b1;
                        end else begin
                            if (cam_rsp_type == RSP_PIVOT)  pivot_cnt  <= pivot_cnt + PCW'(1);
                            if (cam_rsp_type == RSP_NPIVOT) npivot_cnt <= npivot_cnt + NPCW'(1);
                            ana_idx <= '0;
                        end
                    end
                end
                S_ANALYZE: begin
                    if (pivot_cnt == '0) begin
                        done <= 1'b1;
                    end else if (ana_ready) begin
                        if (idx_is_last) done <= 1'b1;
                        else             ana_idx <= ana_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bira_fault_ctrl.sv
// Self-checking bench for bira_fault_ctrl: table-driven fault runs plus
// hand-written sequences for backpressure, flow control and mid-run reset.
module tb_bira_fault_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bist_valid;
    logic        bist_ready;
    logic [9:0]  bist_row;
    logic [9:0]  bist_col;
    logic [1:0]  bist_bnk;
    logic        bist_last;
    logic        cam_wr;
    logic [9:0]  cam_row;
    logic [9:0]  cam_col;
    logic [1:0]  cam_bnk;
    logic        cam_rsp_valid;
    logic [1:0]  cam_rsp_type;
    logic        early_term;
    logic        ana_valid;
    logic        ana_ready;
    logic [2:0]  ana_idx;
    logic        busy;
    logic        done;
    logic        fail;
    logic [3:0]  pivot_cnt;
    logic [4:0]  npivot_cnt;
    logic [15:0] fault_cnt;

    bira_fault_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .bist_valid(bist_valid), .bist_ready(bist_ready),
        .bist_row(bist_row), .bist_col(bist_col), .bist_bnk(bist_bnk), .bist_last(bist_last),
        .cam_wr(cam_wr), .cam_row(cam_row), .cam_col(cam_col), .cam_bnk(cam_bnk),
        .cam_rsp_valid(cam_rsp_valid), .cam_rsp_type(cam_rsp_type),
        .early_term(early_term), .ana_valid(ana_valid), .ana_ready(ana_ready), .ana_idx(ana_idx),
        .busy(busy), .done(done), .fail(fail),
        .pivot_cnt(pivot_cnt), .npivot_cnt(npivot_cnt), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         new_run;
        logic [9:0] row;
        logic [9:0] col;
        logic [1:0] bnk;
        bit         last;
        logic [1:0] rsp;
        int         exp_p;
        int         exp_np;
        int         exp_f;
        bit         exp_fail;
    } vec_t;

    vec_t tbl[$];

    int errors = 0;
    int checks = 0;

    // Monitor state, sampled 1 time unit after the falling edge.
    int et_cnt, et_run, et_max;
    int cw_run, cw_max;
    int hs_cnt, av_seen;
    int idx_q[$];
    bit prev_ready, ready_dbl;
    bit auto_rsp = 1'b0;
    bit rsp_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (early_term) begin
            et_run++;
            if (et_run == 1) et_cnt++;
            if (et_run > et_max) et_max = et_run;
        end else et_run = 0;
        if (cam_wr) begin
            cw_run++;
            if (cw_run > cw_max) cw_max = cw_run;
        end else cw_run = 0;
        if (ana_valid) av_seen++;
        if (ana_valid && ana_ready) begin
            hs_cnt++;
            idx_q.push_back(int'(ana_idx));
        end
        if (bist_ready && prev_ready) ready_dbl = 1'b1;
        prev_ready = bist_ready;
    end

    // CAM model for the flow-control test: answers 00 the cycle after each cam_wr.
    always @(negedge clk) begin
        if (auto_rsp) begin
            if (rsp_pending) begin
                cam_rsp_valid = 1'b1;
                rsp_pending   = 1'b0;
            end else begin
                cam_rsp_valid = 1'b0;
                if (cam_wr) rsp_pending = 1'b1;
            end
        end
    end

    task automatic pulse_start();
        et_cnt = 0; et_max = 0; hs_cnt = 0; av_seen = 0; cw_max = 0;
        idx_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_fault(input vec_t v);
        int n = 0;
        @(negedge clk);
        while (!bist_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bist_ready) begin
            chk("ready_timeout", 32'(bist_ready), 32'd1);
            return;
        end
        bist_valid = 1'b1; bist_row = v.row; bist_col = v.col; bist_bnk = v.bnk; bist_last = v.last;
        @(negedge clk);
        bist_valid = 1'b0; bist_last = 1'b0;
        chk("cam_wr", 32'(cam_wr), 32'd1);
        chk("cam_addr", 32'({cam_row, cam_col, cam_bnk}), 32'({v.row, v.col, v.bnk}));
        @(negedge clk);
        cam_rsp_valid = 1'b1; cam_rsp_type = v.rsp;
        @(negedge clk);
        cam_rsp_valid = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].new_run) pulse_start();
            send_fault(tbl[i]);
            chk($sformatf("row%0d_pivot", i),  32'(pivot_cnt),  32'(tbl[i].exp_p));
            chk($sformatf("row%0d_npivot", i), 32'(npivot_cnt), 32'(tbl[i].exp_np));
            chk($sformatf("row%0d_faults", i), 32'(fault_cnt),  32'(tbl[i].exp_f));
            chk($sformatf("row%0d_fail", i),   32'(fail),       32'(tbl[i].exp_fail));
        end
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 40 && !done; n++) @(negedge clk);
        chk(name, 32'(done), 32'd1);
    endtask

    function automatic logic [21:0] flow_addr(input int k);
        logic [9:0] r;
        logic [9:0] c;
        logic [1:0] b;
        r = 10'(k * 37 + 3);
        c = 10'(k * 11 + 500);
        b = 2'(k);
        return {r, c, b};
    endfunction

    initial begin
        logic [21:0] fa;
        vec_t v;
        bit   hold_ok;
        int   k;

        rst = 1'b1; start = 1'b0; bist_valid = 1'b0; bist_row = '0; bist_col = '0; bist_bnk = '0;
        bist_last = 1'b0; cam_rsp_valid = 1'b0; cam_rsp_type = 2'b00; ana_ready = 1'b1;

        // Normal run: 01, 10, 00 with last on the third fault.
        tbl.push_back('{1'b1, 10'd5,  10'd7, 2'd1, 1'b0, 2'b01, 1, 0, 1, 1'b0});
        tbl.push_back('{1'b0, 10'd20, 10'd3, 2'd2, 1'b0, 2'b10, 1, 1, 2, 1'b0});
        tbl.push_back('{1'b0, 10'd20, 10'd9, 2'd3, 1'b1, 2'b00, 1, 1, 3, 1'b0});
        // PCAM overflow: nine pivots, the ninth response fails with pivot_cnt frozen at 8.
        for (int i = 0; i < 9; i++)
            tbl.push_back('{i == 0, 10'(100 + i), 10'(200 + i), 2'(i), 1'b0, 2'b01,
                            (i < 8) ? i + 1 : 8, 0, i + 1, i == 8});
        // Zero pivots: single merged fault with last.
        tbl.push_back('{1'b1, 10'd1023, 10'd0, 2'd3, 1'b1, 2'b00, 0, 0, 1, 1'b0});
        // Illegal response.
        tbl.push_back('{1'b1, 10'd7, 10'd7, 2'd0, 1'b0, 2'b11, 0, 0, 1, 1'b1});

        // Reset values.
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(bist_ready), 0);
        chk("rst_cam_wr", 32'(cam_wr), 0);
        chk("rst_early_term", 32'(early_term), 0);
        chk("rst_ana", 32'({ana_valid, ana_idx}), 0);
        chk("rst_done_fail", 32'({done, fail}), 0);
        chk("rst_counts", 32'({pivot_cnt, npivot_cnt}), 0);
        chk("rst_fault_cnt", 32'(fault_cnt), 0);
        chk("rst_cam_addr", 32'({cam_row, cam_col, cam_bnk}), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Normal run.
        run_rows(0, 2);
        wait_done("normal_done");
        chk("normal_handshakes", 32'(hs_cnt), 1);
        chk("normal_idx0", (idx_q.size() > 0) ? 32'(idx_q[0]) : 32'hFFFF_FFFF, 0);
        chk("normal_early_term", 32'(et_cnt), 1);
        chk("normal_busy", 32'({busy, fail}), 0);

        // Overflow run.
        run_rows(3, 11);
        @(negedge clk); @(negedge clk);
        chk("ovf_early_term_pulses", 32'(et_cnt), 2);
        chk("ovf_early_term_len", 32'(et_max), 1);
        chk("ovf_no_ana_valid", 32'(av_seen), 0);
        chk("ovf_pivot_frozen", 32'(pivot_cnt), 8);
        chk("ovf_busy_done", 32'({busy, done}), 0);

        // Zero pivots.
        run_rows(12, 12);
        wait_done("zero_done");
        chk("zero_no_ana_valid", 32'(av_seen), 0);

        // Illegal response.
        run_rows(13, 13);
        @(negedge clk); @(negedge clk);
        chk("illegal_early_term", 32'(et_cnt), 2);
        chk("illegal_done", 32'(done), 0);

        // Analyzer backpressure with a stray bist_last while bist_valid is low.
        pulse_start();
        bist_last = 1'b1;
        repeat (3) @(negedge clk);
        bist_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = '{1'b0, 10'(300 + i), 10'(40 + i), 2'(i), i == 3, 2'b01, 0, 0, 0, 1'b0};
            send_fault(v);
        end
        chk("bp_pivot_cnt", 32'(pivot_cnt), 4);
        for (int n = 0; n < 20; n++) begin
            if (ana_valid && ana_idx == 3'd2) break;
            @(negedge clk);
        end
        ana_ready = 1'b0;
        hold_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(ana_valid && ana_idx == 3'd2)) hold_ok = 1'b0;
        end
        chk("bp_hold_idx2", 32'(hold_ok), 1);
        ana_ready = 1'b1;
        wait_done("bp_done");
        chk("bp_handshakes", 32'(hs_cnt), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bp_order%0d", i), (idx_q.size() > i) ? 32'(idx_q[i]) : 32'hFFFF_FFFF, 32'(i));

        // Flow control: bist_valid held high, start pulsed while busy.
        pulse_start();
        ready_dbl = 1'b0;
        cam_rsp_type = 2'b00;
        auto_rsp = 1'b1;
        k = 0;
        fa = flow_addr(0);
        {bist_row, bist_col, bist_bnk} = fa;
        bist_last = 1'b0;
        bist_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && k < 6; cyc++) begin
            @(negedge clk);
            start = (cyc == 4);
            if (cam_wr) begin
                chk($sformatf("flow_addr%0d", k), 32'({cam_row, cam_col, cam_bnk}), 32'(flow_addr(k)));
                k++;
                if (k < 6) begin
                    fa = flow_addr(k);
                    {bist_row, bist_col, bist_bnk} = fa;
                    bist_last = (k == 5);
                end else begin
                    bist_valid = 1'b0;
                    bist_last  = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("flow_accepted", 32'(k), 6);
        wait_done("flow_done");
        auto_rsp = 1'b0;
        cam_rsp_valid = 1'b0;
        chk("flow_fault_cnt", 32'(fault_cnt), 6);
        chk("flow_ready_not_back_to_back", 32'(ready_dbl), 0);
        chk("flow_cam_wr_len", 32'(cw_max), 1);
        chk("flow_start_ignored", 32'(et_cnt), 1);

        // Asynchronous reset in the middle of COLLECT.
        pulse_start();
        v = '{1'b0, 10'd11, 10'd22, 2'd1, 1'b0, 2'b01, 0, 0, 0, 1'b0};
        send_fault(v);
        chk("mid_pre_fault_cnt", 32'(fault_cnt), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cam_wr", 32'(cam_wr), 0);
        chk("mid_rst_counts", 32'({pivot_cnt, npivot_cnt, fault_cnt}), 0);
        chk("mid_rst_ready", 32'(bist_ready), 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("mid_idle_busy", 32'({busy, done, fail}), 0);
        chk("mid_no_early_term", 32'(et_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
